mips_muldiv: RTL

//  Iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/mips_muldiv.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MULDIV_ZERO_SHORTCUT_EN to finish divide-by-zero one edge after start.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e                 state;
  logic [CntW-1:0]        count;
  // Multiply: {accumulator, multiplier}; divide: {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   is_div;
  logic                   neg;
  logic                   rneg;
  logic                   divz;

  logic                   sa;
  logic                   sb;
  logic [WIDTH-1:0]       a_abs;
  logic [WIDTH-1:0]       b_abs;
  logic                   b_zero;
  logic                   go_fix;
  logic [WIDTH-1:0]       addend;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_step;
  logic [WIDTH:0]         div_shift;
  logic                   div_ge;
  logic [WIDTH-1:0]       div_diff;
  logic [2*WIDTH-1:0]     div_step;
  logic [2*WIDTH-1:0]     mul_res;
  logic [WIDTH-1:0]       fix_hi;
  logic [WIDTH-1:0]       fix_lo;

  always_comb begin
    sa     = ~op[0] & src_a[WIDTH-1];
    sb     = ~op[0] & src_b[WIDTH-1];
    a_abs  = sa ? -src_a : src_a;
    b_abs  = sb ? -src_b : src_b;
    b_zero = (src_b == '0);
`ifdef MULDIV_ZERO_SHORTCUT_EN
    go_fix = op[1] & b_zero;
`else
    go_fix = 1'b0;
`endif

    addend   = prod[0] ? a_q : '0;
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_step = {mul_sum, prod[WIDTH-1:1]};

    // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
    div_shift = prod[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    div_step  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};

    mul_res = neg ? -prod : prod;
    if (divz) begin
      fix_hi = rneg ? -a_q : a_q;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = rneg ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      fix_lo = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    end else begin
      fix_hi = mul_res[2*WIDTH-1:WIDTH];
      fix_lo = mul_res[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      count    <= '0;
      prod     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div   <= 1'b0;
      neg      <= 1'b0;
      rneg     <= 1'b0;
      divz     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            is_div <= op[1];
            neg    <= sa ^ sb;
            rneg   <= sa;
            divz   <= op[1] & b_zero;
            a_q    <= a_abs;
            b_q    <= b_abs;
            prod   <= op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            count  <= '0;
            busy   <= 1'b1;
            state  <= go_fix ? StFix : StRun;
          end else begin
            if (mthi) hi <= src_a;
            if (mtlo) lo <= src_a;
          end
        end
        StRun: begin
          prod  <= is_div ? div_step : mul_step;
          count <= count + CntW'(1);
          if (count == CntW'(WIDTH - 1)) state <= StFix;
        end
        StFix: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          done     <= 1'b1;
          div_zero <= divz;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
